// File: rtl/pm_fetch_wait.sv
// Instruction fetch: holds pm_addr for WAIT_CYCLES edges, then captures pm_data into ir.
// Latency: first capture on the WAIT_CYCLES-th edge after reset or jump; ir/ir_valid are registered.
// Backpressure: with ir_valid set and ir_ready low, address and wait state hold until the slot frees.
module pm_fetch_wait #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [CNT_W-1:0]  fetch_count
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_cfg
            $error("pm_fetch_wait: WAIT_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   ir_d;
    logic                vld_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                slot_free;
    logic                capture;

    assign slot_free = !ir_valid || ir_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_WAIT;
            wcnt_q      <= '0;
            pm_addr     <= '0;
            ir          <= '0;
            ir_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            pm_addr     <= addr_d;
            ir          <= ir_d;
            ir_valid    <= vld_d;
            fetch_count <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = pm_addr;
        ir_d    = ir;
        vld_d   = ir_valid;
        cnt_d   = fetch_count;
        capture = 1'b0;

        if (jump) begin
            // Jump flushes everything in flight and restarts the settle window.
            addr_d  = jump_addr;
            vld_d   = 1'b0;
            wcnt_d  = '0;
            state_d = S_WAIT;
        end else begin
            capture = slot_free && ((state_q == S_READY) || (wcnt_q == WLAST));
            if (capture) begin
                ir_d    = pm_data;
                vld_d   = 1'b1;
                addr_d  = pm_addr + ADDR_W'(1);
                wcnt_d  = '0;
                state_d = S_WAIT;
                cnt_d   = fetch_count + CNT_W'(1);
            end else begin
                if (ir_valid && ir_ready) begin
                    vld_d = 1'b0;
                end
                if (state_q == S_WAIT) begin
                    if (wcnt_q < WLAST) begin
                        wcnt_d = wcnt_q + 4'd1;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
        end
    end

endmodule

// File: doc/pm_fetch_wait.md
Name: pm_fetch_wait

Overview:
- Instruction-fetch stage for the slow-ROM microprocessor.
- Drives the program-memory address and waits a fixed number of cycles for the ROM and its slow combinational output path to settle.
- Captures the settled byte into an instruction register, then hands it to the decoder over a valid/ready handshake.
- Sits directly downstream of the program-memory output path and upstream of instruction decode.

Parameters:
- ADDR_W, 8, program-memory address width.
- DATA_W, 8, instruction width; matches the program-memory data bus.
- WAIT_CYCLES, 3, clock edges the address is held before pm_data is sampled. Legal range 1..15.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pm_addr  output  ADDR_W  program-memory address, registered.
- pm_data  input  DATA_W  settled program-memory output.
- jump  input  1  load a new fetch address this cycle.
- jump_addr  input  ADDR_W  target address when jump=1.
- ir  output  DATA_W  captured instruction, registered.
- ir_valid  output  1  ir holds an unconsumed instruction.
- ir_ready  input  1  decoder accepts ir this cycle.
- fetch_count  output  CNT_W  number of instructions captured since reset.

Behaviour:
- Reset (reset_n=0, asynchronous) forces:
  - pm_addr=0, ir=0, ir_valid=0, fetch_count=0
  - wait counter wcnt=0, state=WAIT
- Reset takes effect immediately, including mid-wait or while ir_valid=1. The pending instruction is discarded.
- Define slot_free = !ir_valid | ir_ready.
- State machine (2 states), evaluated at each rising edge:
  - WAIT:
    - If wcnt < WAIT_CYCLES-1: wcnt++, stay in WAIT.
    - Else if slot_free: capture.
    - Else: go to READY. wcnt holds at WAIT_CYCLES-1.
  - READY (settle time elapsed, output slot occupied):
    - If slot_free: capture.
    - Else: stay in READY. pm_addr and wcnt hold.
- Capture edge (single edge, all of):
  - ir<=pm_data, ir_valid<=1
  - pm_addr<=pm_addr+1, modulo 2^ADDR_W (0xFF wraps to 0x00)
  - wcnt<=0, state<=WAIT
  - fetch_count<=fetch_count+1, wrapping at 2^CNT_W
- Consume without capture: if ir_valid & ir_ready and no capture on that edge, ir_valid<=0 and ir holds its value.
- Consume and capture on the same edge: ir_valid stays 1 and ir takes the new byte. This is back-to-back handoff with no bubble.
- Jump (highest priority, beats capture and consume):
  - pm_addr<=jump_addr, ir_valid<=0, wcnt<=0, state<=WAIT
  - ir and fetch_count unchanged
  - Any in-flight or unconsumed instruction is flushed.
- jump on consecutive edges: each jump restarts the wait against the newest jump_addr.
- Latency: after reset release or after a jump edge, the first capture occurs on the WAIT_CYCLES-th rising edge if the slot is free.
- Throughput: one instruction per WAIT_CYCLES cycles with ir_ready held 1. With WAIT_CYCLES=1, one per cycle.
- pm_addr never changes except on capture, jump, or reset. This keeps pm_data stable for the whole wait window.
- ir and ir_valid are driven only from registers. No combinational path from pm_data or ir_ready to any output.
- WAIT_CYCLES outside 1..15 is a configuration error; the implementation flags it with an elaboration-time check.

Test Plan:
- Reset latency:
  - Stimulus: WAIT_CYCLES=3, ROM[0]=0xA5, ir_ready=1, release reset_n.
  - Required: ir_valid rises after edge 3 with ir=0xA5, pm_addr=0x01, fetch_count=1.
- Back-pressure:
  - Stimulus: ir_ready=0 after the first capture for 10 cycles.
  - Required: ir=0xA5 and ir_valid=1 held; pm_addr stays 0x01.
  - Stimulus: then raise ir_ready for 1 cycle.
  - Required: next ROM[1] captured on that edge, no bubble.
- Jump flush:
  - Stimulus: ir_valid=1; assert jump with jump_addr=0x40 for 1 cycle.
  - Required: ir_valid=0 next edge, pm_addr=0x40; ROM[0x40] appears 3 edges later; fetch_count not incremented by the flush.
- Address wrap:
  - Stimulus: jump_addr=0xFF, ir_ready=1.
  - Required: capture of ROM[0xFF], then pm_addr=0x00; next capture is ROM[0x00].
- Jump coincident with capture edge:
  - Stimulus: assert jump on the edge where wcnt=WAIT_CYCLES-1.
  - Required: no capture, fetch_count unchanged, pm_addr=jump_addr.
- Reset mid-wait and throughput:
  - Stimulus: drop reset_n while wcnt=1 and ir_valid=1.
  - Required: all outputs 0 immediately.
  - Stimulus: WAIT_CYCLES=1 build, ir_ready=1 for 8 cycles.
  - Required: 8 consecutive captures of ROM[0..7], fetch_count=8.
